// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared encodings and defaults for the instruction fetch stage
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'd0,
    PC_BR   = 2'd1,
    PC_WD   = 2'd2,
    PC_HOLD = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - single-outstanding request/ack bus to instruction memory
interface inst_fetch_if #(
  parameter int ADDR_W = 32
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/inst_fetch_pc_next_calc.sv
// rtl/inst_fetch_pc_next_calc.sv - combinational next-PC select with misalignment detect
module inst_fetch_pc_next_calc
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_src,
  input  logic [23:0]       imm24,
  input  logic [ADDR_W-1:0] pc_wdata,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misalign_det
);

  logic [ADDR_W-1:0] br_offset;

  // Word offset: sign-extended imm24 scaled by 4; all sums wrap at ADDR_W bits.
  assign br_offset = {{(ADDR_W-26){imm24[23]}}, imm24, 2'b00};

  always_comb begin
    next_pc      = pc;
    misalign_det = 1'b0;
    unique case (pc_src)
      PC_SEQ:  next_pc = pc + ADDR_W'(4);
      PC_BR:   next_pc = pc + br_offset;
      PC_WD: begin
        next_pc      = {pc_wdata[ADDR_W-1:2], 2'b00};
        misalign_det = (pc_wdata[1:0] != 2'b00);
      end
      PC_HOLD: next_pc = pc;
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC, one-word prefetch buffer, IR and imem request FSM
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_pc,
  input  logic              write_ir,
  input  logic [1:0]        pc_src,
  input  logic [23:0]       imm24,
  input  logic [ADDR_W-1:0] pc_wdata,
  inst_fetch_if.master      imem,
  output logic [31:0]       I,
  output logic              W_IR_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0]       ir_q;
  logic [31:0]       buf_q;
  logic              buf_valid;
  logic              req_q;
  logic              misalign_q;
  logic              misalign_det;

  inst_fetch_pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next_calc (
    .pc           (pc_q),
    .pc_src       (pc_src),
    .imm24        (imm24),
    .pc_wdata     (pc_wdata),
    .next_pc      (next_pc),
    .misalign_det (misalign_det)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      ir_q       <= '0;
      buf_q      <= '0;
      buf_valid  <= 1'b0;
      misalign_q <= 1'b0;
      state      <= F_REQ;
      req_q      <= 1'b1;
      req_addr   <= RESET_VECTOR;
    end else begin
      if (write_pc) begin
        pc_q <= next_pc;
        if (misalign_det) misalign_q <= 1'b1;
      end
      if (write_ir && buf_valid) ir_q <= buf_q;
      if (write_pc || write_ir) buf_valid <= 1'b0;

      // buf_valid is only ever 1 in F_IDLE, so the fill below never races an IR load.
      unique case (state)
        F_IDLE: begin
          if (write_pc) begin
            state    <= F_REQ;
            req_q    <= 1'b1;
            req_addr <= next_pc;
          end else if (!buf_valid) begin
            state    <= F_REQ;
            req_q    <= 1'b1;
            req_addr <= pc_q;
          end
        end
        F_REQ: begin
          if (imem.imem_ack) begin
            if (write_pc) begin
              req_addr <= next_pc;
            end else begin
              buf_q     <= imem.imem_rdata;
              buf_valid <= 1'b1;
              state     <= F_IDLE;
              req_q     <= 1'b0;
            end
          end else if (write_pc) begin
            state <= F_DROP;
          end
        end
        F_DROP: begin
          if (imem.imem_ack) begin
            state    <= F_REQ;
            req_addr <= write_pc ? next_pc : pc_q;
          end
        end
        default: begin
          state    <= F_REQ;
          req_q    <= 1'b1;
          req_addr <= pc_q;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = req_addr;
  assign I              = ir_q;
  assign W_IR_valid     = buf_valid;
  assign pc             = pc_q;
  assign misalign       = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_pc;
  logic        write_ir;
  logic [1:0]  pc_src;
  logic [23:0] imm24;
  logic [31:0] pc_wdata;
  logic [31:0] I;
  logic        W_IR_valid;
  logic [31:0] pc;
  logic        misalign;

  int passes = 0;
  int total  = 0;

  inst_fetch_if #(.ADDR_W(32)) imem ();

  inst_fetch #(.ADDR_W(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_pc   (write_pc),
    .write_ir   (write_ir),
    .pc_src     (pc_src),
    .imm24      (imm24),
    .pc_wdata   (pc_wdata),
    .imem       (imem),
    .I          (I),
    .W_IR_valid (W_IR_valid),
    .pc         (pc),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    write_pc        = 1'b0;
    write_ir        = 1'b0;
    pc_src          = 2'd3;
    imm24           = 24'h0;
    pc_wdata        = 32'h0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_pc", pc, 32'h0);
    check("rst_ir", I, 32'h0);
    check("rst_valid", 32'(W_IR_valid), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_req", 32'(imem.imem_req), 32'd1);
    check("rst_addr", imem.imem_addr, 32'h0);

    tick();
    check("wait_req", 32'(imem.imem_req), 32'd1);
    check("wait_valid", 32'(W_IR_valid), 32'd0);

    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hE3A0_1005;
    tick();
    idle_inputs();
    check("fill_valid", 32'(W_IR_valid), 32'd1);
    check("fill_req", 32'(imem.imem_req), 32'd0);

    write_ir = 1'b1;
    tick();
    idle_inputs();
    check("load_ir", I, 32'hE3A0_1005);
    check("load_valid", 32'(W_IR_valid), 32'd0);

    write_pc = 1'b1; pc_src = 2'd2; pc_wdata = 32'h10;
    tick();
    idle_inputs();
    check("jump_pc", pc, 32'h10);
    check("jump_addr", imem.imem_addr, 32'h10);
    check("jump_misalign", 32'(misalign), 32'd0);

    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h1111_1111;
    tick();
    idle_inputs();
    check("fill2_valid", 32'(W_IR_valid), 32'd1);

    write_ir = 1'b1; write_pc = 1'b1; pc_src = 2'd0;
    tick();
    idle_inputs();
    check("seq_pc", pc, 32'h14);
    check("seq_req", 32'(imem.imem_req), 32'd1);
    check("seq_addr", imem.imem_addr, 32'h14);
    check("seq_ir", I, 32'h1111_1111);
    check("seq_valid", 32'(W_IR_valid), 32'd0);

    write_pc = 1'b1; pc_src = 2'd1; imm24 = 24'hFF_FFFE;
    tick();
    idle_inputs();
    check("br_pc", pc, 32'h0C);
    check("br_drop_req", 32'(imem.imem_req), 32'd1);
    check("br_drop_addr", imem.imem_addr, 32'h14);

    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("drop_valid", 32'(W_IR_valid), 32'd0);
    check("drop_req", 32'(imem.imem_req), 32'd1);
    check("drop_readdr", imem.imem_addr, 32'h0C);

    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h2222_2222;
    write_pc = 1'b1; pc_src = 2'd2; pc_wdata = 32'h103;
    tick();
    idle_inputs();
    check("ackpc_pc", pc, 32'h100);
    check("ackpc_misalign", 32'(misalign), 32'd1);
    check("ackpc_valid", 32'(W_IR_valid), 32'd0);
    check("ackpc_addr", imem.imem_addr, 32'h100);

    write_ir = 1'b1;
    tick();
    idle_inputs();
    check("noload_ir", I, 32'h1111_1111);
    check("noload_req", 32'(imem.imem_req), 32'd1);
    check("noload_addr", imem.imem_addr, 32'h100);

    write_pc = 1'b1; pc_src = 2'd3;
    tick();
    idle_inputs();
    check("hold_pc", pc, 32'h100);
    check("hold_addr", imem.imem_addr, 32'h100);
    check("hold_misalign", 32'(misalign), 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_pc", pc, 32'h0);
    check("rst2_ir", I, 32'h0);
    check("rst2_misalign", 32'(misalign), 32'd0);
    check("rst2_valid", 32'(W_IR_valid), 32'd0);
    check("rst2_req", 32'(imem.imem_req), 32'd1);
    check("rst2_addr", imem.imem_addr, 32'h0);

    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    check("rst2_fill", 32'(W_IR_valid), 32'd1);

    write_pc = 1'b1; pc_src = 2'd2; pc_wdata = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_valid", 32'(W_IR_valid), 32'd0);

    write_pc = 1'b1; pc_src = 2'd0;
    tick();
    idle_inputs();
    check("wrap_pc", pc, 32'h0);
    check("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
